add_pipe: RTL and testbench

//  Parametrised pipelined adder/subtractor for the datapath. Generalises the
//  1-bit full-adder cell to a WIDTH-bit operation split into SEG-bit ripple

---
 rtl/add_pipe.sv | 165 ++++++++++++++++
 tb/tb_add_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// add_pipe -- pipelined WIDTH-bit adder/subtractor built from SEG-bit ripple
// segments, one segment per pipeline stage (STAGES = WIDTH/SEG).
//
// Operation:
//    sub = 0 : {cout, sum} = a + b + cin
//    sub = 1 : {cout, sum} = a - b   (cout = 1 means no borrow, a >= b unsigned)
//
// Ports:
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous reset, active low
//    in_valid   in   operands valid this cycle
//    in_ready   out  operands are taken this cycle (combinational)
//    a, b       in   WIDTH-bit operands
//    cin        in   carry in, only used for addition
//    sub        in   selects subtraction
//    out_valid  out  result valid
//    out_ready  in   consumer takes the result
//    sum        out  WIDTH-bit result, modulo 2^WIDTH
//    cout       out  carry out of the MSB
//    ovf        out  signed overflow, only when ADD_PIPE_OVF_EN is defined
//
// Build option:
//    ADD_PIPE_OVF_EN  adds the ovf port and the single flop behind it.
//
// Every stage advances together: when the result sits unclaimed at the output
// the whole pipe freezes, and empty slots (bubbles) travel along like real
// operations, so latency is always STAGES cycles when unstalled.
// ---------------------------------------------------------------------------
module add_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADD_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / SEG;

    logic             w_advance;
    logic [WIDTH-1:0] w_bEff;
    logic             w_c0;

    // Subtraction is a + ~b + 1, so the operand inversion and the forced
    // carry-in are applied once before the first segment.
    assign w_bEff    = sub ? ~b : b;
    assign w_c0      = sub | cin;

    // The pipe may move whenever the output slot is empty or being taken.
    assign w_advance = out_ready | ~out_valid;
    assign in_ready  = w_advance;

    for (genvar g = 0; g < STAGES; g++) begin : gStage
        // REMIN: operand bits not yet added when entering this stage.
        // DONE : result bits complete after this stage.
        localparam int REMIN = WIDTH - g * SEG;
        localparam int DONE  = (g + 1) * SEG;

        logic [REMIN-1:0] w_a;
        logic [REMIN-1:0] w_b;
        logic             w_cIn;
        logic             w_vIn;
        logic [SEG:0]     w_seg;
        logic [DONE-1:0]  w_sumNext;

        logic             r_v;
        logic             r_c;
        logic [DONE-1:0]  r_sum;

        // Stage inputs come from the ports for the first stage and from the
        // previous stage's registers otherwise. The finished low bits are
        // extended by this stage's segment result on top.
        if (g == 0) begin : gIn
            assign w_a       = a;
            assign w_b       = w_bEff;
            assign w_cIn     = w_c0;
            assign w_vIn     = in_valid;
            assign w_sumNext = w_seg[SEG-1:0];
        end else begin : gIn
            assign w_a       = gStage[g-1].gOps.r_opA;
            assign w_b       = gStage[g-1].gOps.r_opB;
            assign w_cIn     = gStage[g-1].r_c;
            assign w_vIn     = gStage[g-1].r_v;
            assign w_sumNext = {w_seg[SEG-1:0], gStage[g-1].r_sum};
        end

        // One SEG-bit ripple segment; the extra top bit is the segment carry.
        assign w_seg = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_cIn};

        // Valid bit moves on every advance so bubbles keep their slot. Data
        // only loads with a real operation, which keeps sum/cout at the
        // output stable between results.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_advance) begin
                r_v <= w_vIn;
                if (w_vIn) begin
                    r_c   <= w_seg[SEG];
                    r_sum <= w_sumNext;
                end
            end
        end

        // Upper operand bits still to be added travel with the partial sum;
        // the last stage has none left to carry.
        if (g < STAGES - 1) begin : gOps
            logic [REMIN-SEG-1:0] r_opA;
            logic [REMIN-SEG-1:0] r_opB;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_opA <= '0;
                    r_opB <= '0;
                end else if (w_advance && w_vIn) begin
                    r_opA <= w_a[REMIN-1:SEG];
                    r_opB <= w_b[REMIN-1:SEG];
                end
            end
        end
    end

    assign out_valid = gStage[STAGES-1].r_v;
    assign sum       = gStage[STAGES-1].r_sum;
    assign cout      = gStage[STAGES-1].r_c;

`ifdef ADD_PIPE_OVF_EN
    logic r_ovf;
    logic w_ovfNext;

    // The last stage still holds the operand MSBs (top bit of its segment),
    // so overflow is judged there from the operand signs and the result sign.
    assign w_ovfNext = (gStage[STAGES-1].w_a[SEG-1] == gStage[STAGES-1].w_b[SEG-1]) &
                       (gStage[STAGES-1].w_seg[SEG-1] != gStage[STAGES-1].w_a[SEG-1]);

    // Loaded alongside the last stage's sum so it holds under the same rules.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_advance && gStage[STAGES-1].w_vIn) begin
            r_ovf <= w_ovfNext;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_add_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_add_pipe -- self-checking bench for add_pipe at WIDTH=32, SEG=8.
// Expected results come from plain integer arithmetic on the operands and
// are queued in acceptance order; the output is compared with the queue head
// whenever out_valid is high. ovf is checked when ADD_PIPE_OVF_EN is defined.
// ---------------------------------------------------------------------------
module tb_add_pipe;

    localparam int WIDTH  = 32;
    localparam int SEG    = 8;
    localparam int STAGES = WIDTH / SEG;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef ADD_PIPE_OVF_EN
    logic        ovf;
`endif

    int          checkCount = 0;
    int          passCount  = 0;
    logic [33:0] expQ[$];

    add_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADD_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog");
    end

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference result {ovf, cout, sum} from integer arithmetic.
    function automatic logic [33:0] refModel(input logic [31:0] ia, input logic [31:0] ib,
                                             input logic ic, input logic is);
        longint ua, ub, sa, sb, t, s;
        logic   c, o;
        ua = longint'(ia);
        ub = longint'(ib);
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        if (!is) begin
            t = ua + ub + longint'(ic);
            c = t[32];
            s = sa + sb + longint'(ic);
        end else begin
            t = ua - ub;
            c = (ua >= ub);
            s = sa - sb;
        end
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {o, c, t[31:0]};
    endfunction

    // Operand generator biased towards carry and sign corner values.
    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle, entered and left on a falling edge: drive inputs,
    // compare the presented result with the queue head, and predict the
    // handshakes that the coming rising edge will perform.
    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                                 input logic ic, input logic is, input logic ordy,
                                 output logic accepted);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                checkOutput("sum", 64'(sum), 64'(expQ[0][31:0]));
                checkOutput("cout", 64'(cout), 64'(expQ[0][32]));
`ifdef ADD_PIPE_OVF_EN
                checkOutput("ovf", 64'(ovf), 64'(expQ[0][33]));
`endif
                if (ordy) void'(expQ.pop_front());
            end
        end
        accepted = iv && in_ready;
        if (accepted) expQ.push_back(refModel(ia, ib, ic, is));
        @(negedge clk);
    endtask

    // Single operation through an empty pipe: checks acceptance, latency and
    // the result.
    task automatic runOne(input logic [31:0] ia, input logic [31:0] ib, input logic ic, input logic is);
        int   lat;
        logic acc;
        applyStimulus(1'b1, ia, ib, ic, is, 1'b1, acc);
        checkOutput("accept", 64'(acc), 64'd1);
        lat = 1;
        while (!out_valid && lat < 12) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(STAGES));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    // Runs idle cycles until every expected result has been seen.
    task automatic drainPipe(input string tag);
        logic acc;
        for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        end
        checkOutput(tag, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        logic        acc;
        logic        pend;
        logic [31:0] pa, pb;
        logic        pc, ps, ordy;
        int          sent, ops, cyc;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state.
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Subtraction both ways, and cin ignored while subtracting.
        runOne(32'd5, 32'd7, 1'b0, 1'b1);
        runOne(32'd7, 32'd5, 1'b0, 1'b1);
        runOne(32'd7, 32'd5, 1'b1, 1'b1);

        // Reset mid-stream: one result at the output, two more in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h1234_5678 + 32'(i), 32'h1111_1111, 1'b0, 1'b0, 1'b1, acc);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_sum", 64'(sum), 64'd0);
        checkOutput("midrst_cout", 64'(cout), 64'd0);
`ifdef ADD_PIPE_OVF_EN
        checkOutput("midrst_ovf", 64'(ovf), 64'd0);
`endif
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        end

        // Full carry chain through every segment, right after reset.
        runOne(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);

        // Signed overflow cases and a plain non-overflowing add.
        runOne(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        runOne(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        runOne(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);

        // Backpressure: 8 back-to-back ops with a 3-cycle output stall.
        sent = 0;
        for (int c = 0; c < 40 && (sent < 8 || expQ.size() != 0); c++) begin
            ordy = !(c >= 5 && c < 8);
            applyStimulus(sent < 8, $urandom, $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ordy, acc);
            if (c >= 5 && c < 8) checkOutput("stall_accept", 64'(acc), 64'd0);
            if (acc) sent++;
        end
        checkOutput("bp_sent", 64'(sent), 64'd8);
        checkOutput("bp_drain", 64'(expQ.size()), 64'd0);

        // Random traffic with random valid/ready; a refused operand is held.
        ops  = 0;
        cyc  = 0;
        pend = 1'b0;
        pa   = '0;
        pb   = '0;
        pc   = 1'b0;
        ps   = 1'b0;
        while (ops < 10000 && cyc < 60000) begin
            if (!pend && $urandom_range(0, 99) < 70) begin
                pend = 1'b1;
                pa   = randOperand();
                pb   = randOperand();
                pc   = 1'($urandom_range(0, 1));
                ps   = 1'($urandom_range(0, 1));
            end
            ordy = ($urandom_range(0, 99) < 70);
            applyStimulus(pend, pa, pb, pc, ps, ordy, acc);
            if (acc) begin
                pend = 1'b0;
                ops++;
            end
            cyc++;
        end
        checkOutput("rand_ops", 64'(ops), 64'd10000);
        drainPipe("rand_drain");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
